// File: rtl/riscv_pkg.sv
// Shared core constants: the canonical NOP encoding and the pair sequencer state encoding.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        SEQ_EMPTY = 2'd0,
        SEQ_SLOT0 = 2'd1,
        SEQ_SLOT1 = 2'd2
    } seq_state_e;

    // First slot to issue from a freshly captured valid mask {slot0, slot1}
    function automatic seq_state_e capture_state(input logic [1:0] v);
        seq_state_e st;
        if (v[1]) begin
            st = SEQ_SLOT0;
        end else if (v[0]) begin
            st = SEQ_SLOT1;
        end else begin
            st = SEQ_EMPTY;
        end
        return st;
    endfunction

endpackage

// File: rtl/issue_pair_buf.sv
// Pair buffer: 64-bit instruction pair, base PC and per-slot valid mask with load, clear and hold.
module issue_pair_buf
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [63:0] pair_i,
    input  logic [31:0] base_i,
    input  logic [1:0]  v_i,
    output logic        slot1_valid_o,
    output logic [63:0] pair_nxt_o,
    output logic [31:0] base_nxt_o
);

    logic [63:0] pair_q, pair_d;
    logic [31:0] base_q, base_d;
    logic [1:0]  v_q, v_d;

    // Next contents: clear wins over load, otherwise hold
    always_comb begin
        pair_d = pair_q;
        base_d = base_q;
        v_d    = v_q;
        if (clear_i) begin
            v_d = 2'b00;
        end else if (load_i) begin
            pair_d = pair_i;
            base_d = base_i;
            v_d    = v_i;
        end else begin
            v_d = v_q;
        end
    end

    // Buffer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_q <= {NOP_INSTR, NOP_INSTR};
            base_q <= 32'h0000_0000;
            v_q    <= 2'b00;
        end else begin
            pair_q <= pair_d;
            base_q <= base_d;
            v_q    <= v_d;
        end
    end

    // Next values are exported so the issue registers line up with the state they present
    assign slot1_valid_o = v_q[0];
    assign pair_nxt_o    = pair_d;
    assign base_nxt_o    = base_d;

endmodule

// File: rtl/issue_pair_sequencer.sv
// Serialises fetched instruction pairs into a single-issue stream with valid/ready on both sides.
// Build option: SEQ_NOP_SKIP_EN drops NOP slots at capture time.
module issue_pair_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    input  logic [63:0] fetch_instr,
    output logic        fetch_ready,
    output logic        issue_valid,
    output logic [31:0] issue_instr,
    output logic [31:0] issue_pc,
    input  logic        issue_ready,
    input  logic        flush,
    output logic [1:0]  seq_state
);

    seq_state_e  state_q, state_d;
    logic        fetch_ready_s;
    logic        fetch_hs;
    logic        buf_load, buf_clear;
    logic        buf_slot1_valid;
    logic [63:0] pair_nxt;
    logic [31:0] base_nxt;
    logic [31:0] cap_base;
    logic [1:0]  cap_v;
    seq_state_e  cap_state;

    logic        issue_valid_q, issue_valid_d;
    logic [31:0] issue_instr_q, issue_instr_d;
    logic [31:0] issue_pc_q,    issue_pc_d;

    assign cap_base = {fetch_pc[31:3], 1'b0, fetch_pc[1:0]};
`ifdef SEQ_NOP_SKIP_EN
    assign cap_v = {~fetch_pc[2] && (fetch_instr[63:32] != NOP_INSTR),
                    fetch_instr[31:0] != NOP_INSTR};
`else
    assign cap_v = {~fetch_pc[2], 1'b1};
`endif
    assign cap_state = capture_state(cap_v);
    assign fetch_hs  = fetch_valid && fetch_ready_s;

    issue_pair_buf u_buf (
        .clk          (clk),
        .rst          (rst),
        .load_i       (buf_load),
        .clear_i      (buf_clear),
        .pair_i       (fetch_instr),
        .base_i       (cap_base),
        .v_i          (cap_v),
        .slot1_valid_o(buf_slot1_valid),
        .pair_nxt_o   (pair_nxt),
        .base_nxt_o   (base_nxt)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEQ_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and buffer control; flush overrides everything, issue stall freezes
    always_comb begin
        state_d   = state_q;
        buf_load  = 1'b0;
        buf_clear = 1'b0;
        if (flush) begin
            state_d   = SEQ_EMPTY;
            buf_clear = 1'b1;
        end else begin
            case (state_q)
                SEQ_EMPTY: begin
                    if (fetch_hs) begin
                        buf_load = 1'b1;
                        state_d  = cap_state;
                    end else begin
                        state_d  = SEQ_EMPTY;
                    end
                end
                SEQ_SLOT0, SEQ_SLOT1: begin
                    if (!issue_ready) begin
                        state_d = state_q;
                    end else if ((state_q == SEQ_SLOT0) && buf_slot1_valid) begin
                        state_d = SEQ_SLOT1;
                    end else if (fetch_hs) begin
                        buf_load = 1'b1;
                        state_d  = cap_state;
                    end else begin
                        buf_clear = 1'b1;
                        state_d   = SEQ_EMPTY;
                    end
                end
                default: begin
                    state_d   = SEQ_EMPTY;
                    buf_clear = 1'b1;
                end
            endcase
        end
    end

    // Outputs: fetch_ready from current state; issue_* prepared from the next state
    always_comb begin
        fetch_ready_s = 1'b0;
        if (rst || flush) begin
            fetch_ready_s = 1'b0;
        end else begin
            case (state_q)
                SEQ_EMPTY: fetch_ready_s = 1'b1;
                SEQ_SLOT0: fetch_ready_s = issue_ready && !buf_slot1_valid;
                SEQ_SLOT1: fetch_ready_s = issue_ready;
                default:   fetch_ready_s = 1'b0;
            endcase
        end

        case (state_d)
            SEQ_SLOT0: begin
                issue_valid_d = 1'b1;
                issue_instr_d = pair_nxt[63:32];
                issue_pc_d    = base_nxt;
            end
            SEQ_SLOT1: begin
                issue_valid_d = 1'b1;
                issue_instr_d = pair_nxt[31:0];
                issue_pc_d    = base_nxt + 32'd4;
            end
            default: begin
                issue_valid_d = 1'b0;
                issue_instr_d = NOP_INSTR;
                issue_pc_d    = RESET_PC;
            end
        endcase
    end

    // Issue output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_instr_q <= NOP_INSTR;
            issue_pc_q    <= RESET_PC;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_instr_q <= issue_instr_d;
            issue_pc_q    <= issue_pc_d;
        end
    end

    assign fetch_ready = fetch_ready_s;
    assign issue_valid = issue_valid_q;
    assign issue_instr = issue_instr_q;
    assign issue_pc    = issue_pc_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_issue_pair_sequencer.sv
// Bench for issue_pair_sequencer: queue-based reference model plus directed vectors with literal expectations.
module tb_issue_pair_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = 32'h0;
    logic [63:0] fetch_instr = 64'h0;
    logic        issue_ready = 1'b1;
    logic        flush = 1'b0;
    logic        fetch_ready;
    logic        issue_valid;
    logic [31:0] issue_instr;
    logic [31:0] issue_pc;
    logic [1:0]  seq_state;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Model: queue of instructions still to be issued, head is what is presented
    logic [31:0] mq_pc[$];
    logic [31:0] mq_in[$];

    always #5 clk = ~clk;

    issue_pair_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_valid(fetch_valid),
        .fetch_pc   (fetch_pc),
        .fetch_instr(fetch_instr),
        .fetch_ready(fetch_ready),
        .issue_valid(issue_valid),
        .issue_instr(issue_instr),
        .issue_pc   (issue_pc),
        .issue_ready(issue_ready),
        .flush      (flush),
        .seq_state  (seq_state)
    );

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    function automatic logic keep(input logic [31:0] w);
`ifdef SEQ_NOP_SKIP_EN
        return w != NOP;
`else
        return 1'b1;
`endif
    endfunction

    // Accept when nothing is buffered, or when the last buffered instruction leaves this cycle
    function automatic logic fr_model();
        return !rst && !flush && (mq_pc.size() == 0 || (mq_pc.size() == 1 && issue_ready));
    endfunction

    always @(posedge clk) begin : model
        logic        acc;
        logic [31:0] base;
        acc = fr_model() && fetch_valid;
        if (rst || flush) begin
            mq_pc.delete();
            mq_in.delete();
        end else begin
            if (issue_ready && mq_pc.size() > 0) begin
                void'(mq_pc.pop_front());
                void'(mq_in.pop_front());
            end
            if (acc) begin
                base = fetch_pc & 32'hFFFF_FFFB;
                if (!fetch_pc[2] && keep(fetch_instr[63:32])) begin
                    mq_pc.push_back(base);
                    mq_in.push_back(fetch_instr[63:32]);
                end
                if (keep(fetch_instr[31:0])) begin
                    mq_pc.push_back(base + 32'd4);
                    mq_in.push_back(fetch_instr[31:0]);
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("fetch_ready", {63'd0, fetch_ready}, {63'd0, fr_model()});
            chk("issue_valid", {63'd0, issue_valid}, {63'd0, mq_pc.size() > 0});
            chk("issue_instr", {32'd0, issue_instr}, {32'd0, (mq_pc.size() > 0) ? mq_in[0] : NOP});
            chk("issue_pc", {32'd0, issue_pc}, {32'd0, (mq_pc.size() > 0) ? mq_pc[0] : 32'h0});
            chk("seq_state", {62'd0, seq_state},
                {62'd0, (mq_pc.size() == 0) ? 2'd0 : (mq_pc[0][2] ? 2'd2 : 2'd1)});
        end
    end

    task automatic drive(input logic r, input logic fv, input logic [31:0] pc,
                         input logic [63:0] ins, input logic ir, input logic fl);
        rst = r; fetch_valid = fv; fetch_pc = pc; fetch_instr = ins;
        issue_ready = ir; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic expect_out(input string name, input logic v, input logic [31:0] ins,
                              input logic [31:0] pc, input logic [1:0] st);
        chk({name, ".valid"}, {63'd0, issue_valid}, {63'd0, v});
        chk({name, ".instr"}, {32'd0, issue_instr}, {32'd0, ins});
        chk({name, ".pc"},    {32'd0, issue_pc},    {32'd0, pc});
        chk({name, ".state"}, {62'd0, seq_state},   {62'd0, st});
    endtask

    initial begin
        drive(1'b1, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        expect_out("reset", 1'b0, NOP, 32'h0, 2'd0);

        // basic pair
        drive(1'b0, 1'b1, 32'h100, {32'h00500093, 32'h00A00113}, 1'b1, 1'b0);
        expect_out("basic_s0", 1'b1, 32'h00500093, 32'h100, 2'd1);
        idle();
        expect_out("basic_s1", 1'b1, 32'h00A00113, 32'h104, 2'd2);
        idle();
        expect_out("basic_empty", 1'b0, NOP, 32'h0, 2'd0);

        // back-to-back pairs, fetch holds 0x108 until accepted
        drive(1'b0, 1'b1, 32'h100, {32'h00500093, 32'h00A00113}, 1'b1, 1'b0);
        expect_out("b2b_0", 1'b1, 32'h00500093, 32'h100, 2'd1);
        drive(1'b0, 1'b1, 32'h108, {32'h00308193, 32'h00418213}, 1'b1, 1'b0);
        expect_out("b2b_1", 1'b1, 32'h00A00113, 32'h104, 2'd2);
        drive(1'b0, 1'b1, 32'h108, {32'h00308193, 32'h00418213}, 1'b1, 1'b0);
        expect_out("b2b_2", 1'b1, 32'h00308193, 32'h108, 2'd1);
        idle();
        expect_out("b2b_3", 1'b1, 32'h00418213, 32'h10C, 2'd2);
        idle();

        // downstream stall in SLOT0
        drive(1'b0, 1'b1, 32'h300, {32'h11111111, 32'h22222222}, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h308, {32'h33333333, 32'h44444444}, 1'b0, 1'b0);
            expect_out("stall_hold", 1'b1, 32'h11111111, 32'h300, 2'd1);
        end
        drive(1'b0, 1'b0, 32'h0, 64'h0, 1'b1, 1'b0);
        expect_out("stall_s1", 1'b1, 32'h22222222, 32'h304, 2'd2);
        idle();
        expect_out("stall_empty", 1'b0, NOP, 32'h0, 2'd0);

        // flush in SLOT0 with a competing fetch
        drive(1'b0, 1'b1, 32'h200, {32'h55555555, 32'h66666666}, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h400, {32'h77777777, 32'h88888888}, 1'b1, 1'b1);
        expect_out("flush", 1'b0, NOP, 32'h0, 2'd0);
        drive(1'b0, 1'b1, 32'h20C, {32'h99999999, 32'hAAAAAAAA}, 1'b1, 1'b0);
        expect_out("target_s1", 1'b1, 32'hAAAAAAAA, 32'h20C, 2'd2);
        idle();
        expect_out("target_empty", 1'b0, NOP, 32'h0, 2'd0);

        // top of address space, then a pair at 0
        drive(1'b0, 1'b1, 32'hFFFF_FFF8, {32'hBBBBBBBB, 32'hCCCCCCCC}, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h0, {32'hDDDDDDDD, 32'hEEEEEEEE}, 1'b1, 1'b0);
        expect_out("top_s1", 1'b1, 32'hCCCCCCCC, 32'hFFFF_FFFC, 2'd2);
        drive(1'b0, 1'b1, 32'h0, {32'hDDDDDDDD, 32'hEEEEEEEE}, 1'b1, 1'b0);
        expect_out("zero_s0", 1'b1, 32'hDDDDDDDD, 32'h0, 2'd1);
        idle();
        expect_out("zero_s1", 1'b1, 32'hEEEEEEEE, 32'h4, 2'd2);
        idle();

        // reset mid-drain
        drive(1'b0, 1'b1, 32'h500, {32'h12345678, 32'h9ABCDEF0}, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 32'h508, {32'h0F0F0F0F, 32'hF0F0F0F0}, 1'b1, 1'b0);
        expect_out("mid_reset", 1'b0, NOP, 32'h0, 2'd0);
        idle();
        expect_out("after_reset", 1'b0, NOP, 32'h0, 2'd0);

        // NOP handling
        drive(1'b0, 1'b1, 32'h40, {NOP, 32'h00100093}, 1'b1, 1'b0);
`ifdef SEQ_NOP_SKIP_EN
        expect_out("nop_skip", 1'b1, 32'h00100093, 32'h44, 2'd2);
        idle();
        drive(1'b0, 1'b1, 32'h80, {NOP, NOP}, 1'b1, 1'b0);
        expect_out("nop_pair", 1'b0, NOP, 32'h0, 2'd0);
        chk("nop_pair.fetch_ready", {63'd0, fetch_ready}, 64'd1);
        drive(1'b0, 1'b1, 32'h60, {32'h00500093, NOP}, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 32'h68, {32'h00308193, 32'h00418213}, 1'b1, 1'b0);
        expect_out("nop_refill", 1'b1, 32'h00308193, 32'h68, 2'd1);
        idle();
`else
        expect_out("nop_issue", 1'b1, NOP, 32'h40, 2'd1);
        idle();
        expect_out("nop_next", 1'b1, 32'h00100093, 32'h44, 2'd2);
`endif
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
